spi_slave_if: RTL and testbench

SPI responder (mode 0, MSB first) for the far end of the team's SPI bus: it receives frames from the SPI master and returns data on MISO. SCLK, chip select and MOSI are oversampled and edge-detected in the `clk_i` domain. Received words come out as single-cycle pulses. Transmit words are fed through a one-entry holding register with a valid/ready handshake. It sits beside the peripheral model in system benches, and is the slave-side interface for on-chip targets of the bus.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_slave_if_if.sv | 31 +++
 rtl/spi_sync_edge.sv | 25 ++
 rtl/spi_slave_if.sv | 131 +++++++++++++
 tb/tb_spi_slave_if.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and the responder state type
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_SYNC_STAGES = 2;
    localparam logic [31:0] SPI_DUMMY_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_slv_state_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// rtl/spi_slave_if_if.sv - SPI pins plus rx/tx word handshake bundle of the SPI responder
interface spi_slave_if_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic              SCLK_i;
    logic              cs_i;
    logic              MOSI_i;
    logic              MISO_o;
    logic              MISO_oe_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic              busy_o;
    logic              tx_underrun_o;
    logic              clr_i;

    modport slave (
        input  SCLK_i, cs_i, MOSI_i, tx_data_i, tx_valid_i, clr_i,
        output MISO_o, MISO_oe_o, rx_data_o, rx_valid_o, tx_ready_o, busy_o, tx_underrun_o
    );

    modport master (
        output SCLK_i, cs_i, MOSI_i, tx_data_i, tx_valid_i, clr_i,
        input  MISO_o, MISO_oe_o, rx_data_o, rx_valid_o, tx_ready_o, busy_o, tx_underrun_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage input synchronizer with rise/fall pulses
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Not reset on purpose: the chain keeps tracking the pin through reset, so a
    // CS already high at reset release shows no rising edge.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[STAGES-2:0], d_i};
        prev_q <= sync_q[STAGES-1];
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - mode-0 SPI responder; SPI_SLAVE_UNDERRUN_EN enables the sticky underrun flag
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [DATA_W-1:0] DUMMY_WORD  = SPI_DUMMY_WORD[DATA_W-1:0]
) (
    input logic           clk_i,
    input logic           rst_i,
    spi_slave_if_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    spi_slv_state_t state_q, state_d;

    logic sclk_rise, sclk_fall, cs_lvl, cs_rise, mosi_lvl;
    logic unused_sclk_lvl, unused_cs_fall, unused_mosi_rise, unused_mosi_fall;
    logic do_load, do_shift, do_sample;

    logic [DATA_W-1:0] tx_shift_q, rx_shift_q, rx_data_q, hold_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hold_full_q, word_done_q, rx_valid_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i (clk_i), .d_i (bus.SCLK_i), .q_o (unused_sclk_lvl),
        .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i (clk_i), .d_i (bus.cs_i), .q_o (cs_lvl),
        .rise_o(cs_rise), .fall_o(unused_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i (clk_i), .d_i (bus.MOSI_i), .q_o (mosi_lvl),
        .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // CS low is checked as a level so a deselect during LOAD is not missed.
    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_sample = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_rise) state_d = LOAD;
            end
            LOAD: begin
                do_load = 1'b1;
                state_d = cs_lvl ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (!cs_lvl) begin
                    state_d = IDLE;
                end else begin
                    do_sample = sclk_rise;
                    if (sclk_fall) begin
                        if (cnt_q != '0) do_shift = 1'b1;
                        else             do_load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            word_done_q <= 1'b0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            rx_valid_q  <= word_done_q;
            if (word_done_q) rx_data_q <= rx_shift_q;
            word_done_q <= do_sample && (cnt_q == '0);
            if (do_sample) rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_lvl};

            if (do_load) begin
                tx_shift_q <= hold_full_q ? hold_data_q : DUMMY_WORD;
                cnt_q      <= CNT_W'(DATA_W - 1);
            end else if (do_shift) begin
                tx_shift_q <= tx_shift_q << 1;
                cnt_q      <= cnt_q - 1'b1;
            end

            // A load sees the pre-handshake state, so same-cycle data waits for the next word.
            if (do_load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end else if (bus.tx_valid_i && !hold_full_q) begin
                hold_full_q <= 1'b1;
                hold_data_q <= bus.tx_data_i;
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                         underrun_q <= 1'b0;
        else if (do_load && !hold_full_q)  underrun_q <= 1'b1;
        else if (bus.clr_i)                underrun_q <= 1'b0;
    end

    assign bus.tx_underrun_o = underrun_q;
`else
    logic unused_clr;
    assign unused_clr        = bus.clr_i;
    assign bus.tx_underrun_o = 1'b0;
`endif

    assign bus.MISO_oe_o  = (state_q != IDLE);
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.MISO_o     = bus.MISO_oe_o & tx_shift_q[DATA_W-1];
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.tx_ready_o = ~hold_full_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - scoreboard bench for spi_slave_if driving the SPI master side
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int HALF = 6;
`ifdef SPI_SLAVE_UNDERRUN_EN
    localparam logic UR_EN = 1'b1;
`else
    localparam logic UR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_if_if #(.DATA_W(8)) bus ();

    spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2), .DUMMY_WORD(8'hFF)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] fw[3];
    logic [7:0] miso_word;
    int         miso_cnt = 0;
    logic       sclk_prev = 1'b0;
    bit         miso_mon_en = 1'b0;
    bit         watch_idle = 1'b0;
    bit         idle_viol = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a word appears on rx or MISO.
    always @(negedge clk) begin
        if (bus.rx_valid_o) begin
            if (exp_rx.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_unexpected: got rx_valid with 0x%0h expected no word", bus.rx_data_o);
            end else begin
                chk("rx_data", {24'b0, bus.rx_data_o}, {24'b0, exp_rx.pop_front()});
            end
        end
        if (!bus.cs_i) begin
            miso_cnt = 0;
        end else if (miso_mon_en && bus.SCLK_i && !sclk_prev) begin
            miso_word = {miso_word[6:0], bus.MISO_o};
            miso_cnt++;
            if (miso_cnt == 8) begin
                miso_cnt = 0;
                if (exp_miso.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL miso_unexpected: got 0x%0h expected no word", miso_word);
                end else begin
                    chk("miso_word", {24'b0, miso_word}, {24'b0, exp_miso.pop_front()});
                end
            end
        end
        sclk_prev = bus.SCLK_i;
        if (watch_idle && (bus.MISO_oe_o || bus.busy_o)) idle_viol = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        chk("tx_ready_before_push", {31'b0, bus.tx_ready_o}, 32'd1);
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        tick(1);
        bus.tx_valid_i = 1'b0;
        chk("tx_ready_after_push", {31'b0, bus.tx_ready_o}, 32'd0);
    endtask

    task automatic cs_start(input bit clr_on_load);
        bus.cs_i = 1'b1;
        tick(3);
        bus.clr_i = clr_on_load;
        tick(1);
        bus.clr_i = 1'b0;
        tick(6);
    endtask

    task automatic spi_bit(input logic b, input bit last);
        bus.MOSI_i = b;
        tick(HALF);
        bus.SCLK_i = 1'b1;
        tick(HALF);
        bus.SCLK_i = 1'b0;
        if (last) bus.cs_i = 1'b0;
    endtask

    task automatic frame(input int nbits, input bit clr_on_load);
        cs_start(clr_on_load);
        for (int b = 0; b < nbits; b++) begin
            logic [7:0] w;
            w = fw[b / 8];
            spi_bit(w[7 - (b % 8)], b == nbits - 1);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_miso"},     {31'b0, bus.MISO_o},        32'd0);
        chk({p, "_miso_oe"},  {31'b0, bus.MISO_oe_o},     32'd0);
        chk({p, "_rx_data"},  {24'b0, bus.rx_data_o},     32'd0);
        chk({p, "_rx_valid"}, {31'b0, bus.rx_valid_o},    32'd0);
        chk({p, "_tx_ready"}, {31'b0, bus.tx_ready_o},    32'd1);
        chk({p, "_busy"},     {31'b0, bus.busy_o},        32'd0);
        chk({p, "_underrun"}, {31'b0, bus.tx_underrun_o}, 32'd0);
    endtask

    task automatic pulse_clr();
        bus.clr_i = 1'b1;
        tick(1);
        bus.clr_i = 1'b0;
        tick(1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.SCLK_i     = 1'b0;
        bus.cs_i       = 1'b1;
        bus.MOSI_i     = 1'b0;
        bus.tx_data_i  = '0;
        bus.tx_valid_i = 1'b0;
        bus.clr_i      = 1'b0;

        // Reset with CS already high; 20 SCLKs must be ignored.
        tick(6);
        rst = 1'b0;
        tick(1);
        chk_reset("reset");
        watch_idle = 1'b1;
        for (int i = 0; i < 20; i++) spi_bit(i[0], 1'b0);
        watch_idle = 1'b0;
        chk("cs_high_at_reset_ignored", {31'b0, idle_viol}, 32'd0);
        bus.cs_i = 1'b0;
        tick(10);

        // Single word with queued tx data.
        push_tx(8'hA5);
        miso_mon_en = 1'b1;
        fw[0] = 8'h3C;
        exp_rx.push_back(8'h3C);
        exp_miso.push_back(8'hA5);
        frame(8, 1'b0);
        tick(10);
        chk("tx_ready_after_load", {31'b0, bus.tx_ready_o}, 32'd1);
        chk("underrun_single_word", {31'b0, bus.tx_underrun_o}, 32'd0);

        // Back-to-back words with only the first one queued.
        push_tx(8'h11);
        fw = '{8'h01, 8'h80, 8'hFF};
        exp_rx.push_back(8'h01);
        exp_rx.push_back(8'h80);
        exp_rx.push_back(8'hFF);
        exp_miso.push_back(8'h11);
        exp_miso.push_back(8'hFF);
        exp_miso.push_back(8'hFF);
        frame(24, 1'b0);
        tick(10);
        chk("underrun_back_to_back", {31'b0, bus.tx_underrun_o}, {31'b0, UR_EN});

        // Aborted frame after 5 SCLKs, then a clean frame.
        miso_mon_en = 1'b0;
        fw[0] = 8'hB6;
        frame(5, 1'b0);
        tick(4);
        chk("abort_busy", {31'b0, bus.busy_o}, 32'd0);
        chk("abort_miso_oe", {31'b0, bus.MISO_oe_o}, 32'd0);
        tick(10);
        miso_mon_en = 1'b1;
        push_tx(8'h5A);
        fw[0] = 8'hC3;
        exp_rx.push_back(8'hC3);
        exp_miso.push_back(8'h5A);
        frame(8, 1'b0);
        tick(10);

        // Clear colliding with a fresh underrun, then an isolated clear.
        pulse_clr();
        chk("underrun_clr_first", {31'b0, bus.tx_underrun_o}, 32'd0);
        fw[0] = 8'h96;
        exp_rx.push_back(8'h96);
        exp_miso.push_back(8'hFF);
        frame(8, 1'b1);
        tick(10);
        chk("underrun_clr_collision", {31'b0, bus.tx_underrun_o}, {31'b0, UR_EN});
        pulse_clr();
        chk("underrun_clr_isolated", {31'b0, bus.tx_underrun_o}, 32'd0);

        // Reset at bit 4 of a frame.
        miso_mon_en = 1'b0;
        fw[0] = 8'h0F;
        cs_start(1'b0);
        for (int b = 0; b < 4; b++) spi_bit(fw[0][7 - b], 1'b0);
        push_tx(8'hE7);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_reset("reset_mid_frame");
        idle_viol  = 1'b0;
        watch_idle = 1'b1;
        for (int b = 0; b < 4; b++) spi_bit(1'b1, 1'b0);
        watch_idle = 1'b0;
        chk("cs_held_after_reset_ignored", {31'b0, idle_viol}, 32'd0);
        bus.cs_i = 1'b0;
        tick(10);
        miso_mon_en = 1'b1;
        push_tx(8'h3A);
        fw[0] = 8'h5C;
        exp_rx.push_back(8'h5C);
        exp_miso.push_back(8'h3A);
        frame(8, 1'b0);
        tick(10);

        chk("rx_words_outstanding", exp_rx.size(), 32'd0);
        chk("miso_words_outstanding", exp_miso.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
